// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory slave for an RV32 hart.
// A request (store or load) is sampled in IDLE, held for LATENCY cycles and
// completed with a one-cycle o_DM_data_ready pulse in RESP.
// Optional feature macro: DMEM_RESPONDER_ERR_EN adds o_DM_err and turns
// misaligned / out-of-range accesses into flagged no-ops instead of
// aligning down and wrapping.
// Byte-lane logic assumes 32-bit words (4 lanes selected by addr[1:0]).

module dmem_responder #(
    parameter int XLEN      = 32,
    parameter int MEM_WORDS = 1024,
    parameter int LATENCY   = 2
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic [XLEN-1:0] i_DM_Addr,
    input  logic [XLEN-1:0] i_DM_Wd,
    input  logic            i_DM_Wen,
    input  logic            i_DM_MemRead,
    input  logic [2:0]      i_DM_f3,
    output logic            o_DM_data_ready,
    output logic [XLEN-1:0] o_DM_ReadData
`ifdef DMEM_RESPONDER_ERR_EN
    ,
    output logic            o_DM_err
`endif
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam int TOP_W = IDX_W + 2;               // byte address bits covered by storage
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic [3:0]      cnt_reg;

    // latched request
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wd_reg;
    logic [2:0]      f3_reg;
    logic            store_reg;

    logic            sample;
    logic            is_byte, is_half, is_word;
    logic [1:0]      eff_lane;
    logic            access_err;
    logic            wr_en;
    logic [IDX_W-1:0] rd_idx, wr_idx;

    logic [XLEN-1:0] mem [MEM_WORDS];
    logic [XLEN-1:0] rd_word_reg;

    logic [7:0]      wr_bytes [4];
    logic            be       [4];
    logic [7:0]      rd_bytes [4];
    logic [7:0]      sel_byte;
    logic [15:0]     sel_half;

    // A request is only accepted while idle; Wen wins over MemRead.
    assign sample = (state_reg == ST_IDLE) && (i_DM_Wen || i_DM_MemRead);

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: LATENCY=1 skips WAIT entirely
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (sample) begin
                    state_next = (LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = ST_RESP;
                end
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Wait counter: loaded on sample, counts down while waiting
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_reg <= 4'd0;
        end else if (sample) begin
            cnt_reg <= CNT_INIT;
        end else if ((state_reg == ST_WAIT) && (cnt_reg != 4'd0)) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Request capture: inputs are frozen at the sample edge
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            addr_reg  <= '0;
            wd_reg    <= '0;
            f3_reg    <= 3'd0;
            store_reg <= 1'b0;
        end else if (sample) begin
            addr_reg  <= i_DM_Addr;
            wd_reg    <= i_DM_Wd;
            f3_reg    <= i_DM_f3;
            store_reg <= i_DM_Wen;
        end
    end

    // Access size from funct3 low bits; 011/110/111 fall through to word
    assign is_byte = (f3_reg[1:0] == 2'b00);
    assign is_half = (f3_reg[1:0] == 2'b01);
    assign is_word = !is_byte && !is_half;

    // Lane after aligning down: halfwords drop addr[0], words drop addr[1:0]
    assign eff_lane = is_byte ? addr_reg[1:0] :
                      is_half ? {addr_reg[1], 1'b0} : 2'b00;

`ifdef DMEM_RESPONDER_ERR_EN
    logic misaligned;
    logic out_of_range;
    assign misaligned = (is_half && addr_reg[0]) || (is_word && (addr_reg[1:0] != 2'b00));
    generate
        if (TOP_W < XLEN) begin : g_range
            assign out_of_range = |addr_reg[XLEN-1:TOP_W];
        end else begin : g_no_range
            assign out_of_range = 1'b0;
        end
    endgenerate
    assign access_err = misaligned || out_of_range;
    assign o_DM_err   = (state_reg == ST_RESP) && access_err;
`else
    assign access_err = 1'b0;
`endif

    // Address bits above the storage window only matter for range errors
    generate
        if (TOP_W < XLEN) begin : g_unused
            logic unused_addr_bits;
            assign unused_addr_bits = ^addr_reg[XLEN-1:TOP_W];
        end
    endgenerate

    // Per-lane store data and byte enables
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign wr_bytes[gi] = is_byte ? wd_reg[7:0] :
                                  is_half ? wd_reg[8*(gi%2) +: 8] :
                                            wd_reg[8*gi +: 8];
            assign be[gi] = is_word ||
                            (is_half && (eff_lane[1] == LANE[1])) ||
                            (is_byte && (eff_lane == LANE));
            assign rd_bytes[gi] = rd_word_reg[8*gi +: 8];
        end
    endgenerate

    // Stores commit on the edge that leaves RESP; a reset drops RESP first
    assign wr_en  = (state_reg == ST_RESP) && store_reg && !access_err;
    assign wr_idx = addr_reg[TOP_W-1:2];
    // In IDLE the read port follows the live address so LATENCY=1 loads
    // have data ready in RESP; afterwards it follows the latched address.
    assign rd_idx = (state_reg == ST_IDLE) ? i_DM_Addr[TOP_W-1:2] : addr_reg[TOP_W-1:2];

    // Storage: byte-enabled write, registered read (block RAM)
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[wr_idx][8*b +: 8] <= wr_bytes[b];
                end
            end
        end
        rd_word_reg <= mem[rd_idx];
    end

    assign sel_byte = rd_bytes[eff_lane];
    assign sel_half = {rd_bytes[{eff_lane[1], 1'b1}], rd_bytes[{eff_lane[1], 1'b0}]};

    // Outputs: pulse in RESP, load data only for error-free loads
    always_comb begin
        o_DM_data_ready = (state_reg == ST_RESP);
        o_DM_ReadData   = '0;
        if ((state_reg == ST_RESP) && !store_reg && !access_err) begin
            case (f3_reg)
                3'b000:  o_DM_ReadData = {{(XLEN-8){sel_byte[7]}}, sel_byte};
                3'b100:  o_DM_ReadData = {{(XLEN-8){1'b0}}, sel_byte};
                3'b001:  o_DM_ReadData = {{(XLEN-16){sel_half[15]}}, sel_half};
                3'b101:  o_DM_ReadData = {{(XLEN-16){1'b0}}, sel_half};
                default: o_DM_ReadData = rd_word_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: a LATENCY=2 instance for data checks and a
// LATENCY=1 instance for back-to-back timing, checked against a byte-array
// model of the memory.
module tb_dmem_responder;

    localparam int MW    = 64;
    localparam int BYTES = 4 * MW;
    localparam int LAT0  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [31:0] addr0, wd0, rdata0;
    logic        wen0, rd0, rdy0;
    logic [2:0]  f30;
    logic [31:0] addr1, wd1, rdata1;
    logic        wen1, rd1, rdy1;
    logic [2:0]  f31;
`ifdef DMEM_RESPONDER_ERR_EN
    logic err0, err1;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] mb [2][BYTES];

    always #5 clk = ~clk;

    dmem_responder #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(LAT0)) dut0 (
        .i_clk(clk), .i_rst(rst_n),
        .i_DM_Addr(addr0), .i_DM_Wd(wd0), .i_DM_Wen(wen0), .i_DM_MemRead(rd0),
        .i_DM_f3(f30), .o_DM_data_ready(rdy0), .o_DM_ReadData(rdata0)
`ifdef DMEM_RESPONDER_ERR_EN
        , .o_DM_err(err0)
`endif
    );

    dmem_responder #(.XLEN(32), .MEM_WORDS(MW), .LATENCY(1)) dut1 (
        .i_clk(clk), .i_rst(rst_n),
        .i_DM_Addr(addr1), .i_DM_Wd(wd1), .i_DM_Wen(wen1), .i_DM_MemRead(rd1),
        .i_DM_f3(f31), .o_DM_data_ready(rdy1), .o_DM_ReadData(rdata1)
`ifdef DMEM_RESPONDER_ERR_EN
        , .o_DM_err(err1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned sz(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic bit m_err(input logic [31:0] a, input logic [2:0] f3);
`ifdef DMEM_RESPONDER_ERR_EN
        return ((a % sz(f3)) != 0) || (a >= BYTES);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned m_base(input logic [31:0] a, input logic [2:0] f3);
        int unsigned e;
        e = a % BYTES;
        return e - (e % sz(f3));
    endfunction

    function automatic logic [31:0] m_load(input int sel, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int unsigned b;
        v = '0;
        if (m_err(a, f3)) return '0;
        b = m_base(a, f3);
        for (int i = 0; i < int'(sz(f3)); i++) v[8*i +: 8] = mb[sel][b + i];
        if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
        if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction

    task automatic m_store(input int sel, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        int unsigned b;
        if (m_err(a, f3)) return;
        b = m_base(a, f3);
        for (int i = 0; i < int'(sz(f3)); i++) mb[sel][b + i] = wd[8*i +: 8];
    endtask

    // ---------------- drivers ----------------
    task automatic set_req(input int sel, input logic w, input logic r,
                           input logic [31:0] a, input logic [31:0] d, input logic [2:0] f);
        if (sel == 0) begin
            wen0 = w; rd0 = r; addr0 = a; wd0 = d; f30 = f;
        end else begin
            wen1 = w; rd1 = r; addr1 = a; wd1 = d; f31 = f;
        end
    endtask

    function automatic logic get_rdy(input int sel);
        return (sel == 0) ? rdy0 : rdy1;
    endfunction

    function automatic logic [31:0] get_data(input int sel);
        return (sel == 0) ? rdata0 : rdata1;
    endfunction

    function automatic logic get_err(input int sel);
`ifdef DMEM_RESPONDER_ERR_EN
        return (sel == 0) ? err0 : err1;
`else
        return (sel < 0);
`endif
    endfunction

    // One request, called and returning at a falling edge.
    task automatic do_txn(input int sel, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] f,
                          output logic [31:0] rdata, output logic oerr);
        int lat;
        int got;
        logic [31:0] exp_d;
        logic exp_e;
        lat   = (sel == 0) ? LAT0 : 1;
        exp_d = w ? 32'd0 : m_load(sel, a, f);
        exp_e = m_err(a, f);
        rdata = '0;
        oerr  = 1'b0;
        got   = 0;
        set_req(sel, w, r, a, d, f);
        @(posedge clk);
        @(negedge clk);
        // scramble inputs: the access must use the latched copy
        set_req(sel, 1'b0, 1'b0, $urandom, $urandom, 3'($urandom_range(0, 7)));
        for (int c = 1; c <= 20; c++) begin
            if (c > 1) @(negedge clk);
            if (get_rdy(sel)) begin
                got = c;
                break;
            end
            if (c == 1) check("idle_data_zero", get_data(sel), 32'd0);
        end
        check("latency", got, lat);
        if (got != 0) begin
            rdata = get_data(sel);
            oerr  = get_err(sel);
            check(w ? "store_data_zero" : "load_data", rdata, exp_d);
`ifdef DMEM_RESPONDER_ERR_EN
            check("err_flag", oerr, exp_e);
`endif
            @(negedge clk);
            check("pulse_width", get_rdy(sel), 1'b0);
        end
        if (w) m_store(sel, a, d, f);
        $display("txn dut=%0d %s addr=%h wd=%h f3=%b data=%h err=%0b lat=%0d",
                 sel, w ? "ST" : "LD", a, d, f, rdata, oerr, got);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] rv;
        logic        ev;
        int          pulses;
        logic [31:0] ra;
        int          op;

        for (int s = 0; s < 2; s++)
            for (int i = 0; i < BYTES; i++) mb[s][i] = 8'h00;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0, 3'd0);

        // reset state
        #2;
        check("reset_rdy0", rdy0, 1'b0);
        check("reset_data0", rdata0, 32'd0);
        check("reset_rdy1", rdy1, 1'b0);
        check("reset_data1", rdata1, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // clear storage of the LATENCY=2 instance
        for (int wi = 0; wi < MW; wi++) do_txn(0, 1'b1, 1'b0, 32'(4 * wi), 32'd0, 3'b010, rv, ev);

        // SW / LW round trip
        do_txn(0, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 3'b010, rv, ev);
        do_txn(0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, rv, ev);
        check("lw_deadbeef", rv, 32'hDEADBEEF);

        // sub-word loads with sign / zero extension
        do_txn(0, 1'b1, 1'b0, 32'h20, 32'h80FF7F01, 3'b010, rv, ev);
        do_txn(0, 1'b0, 1'b1, 32'h23, 32'h0, 3'b000, rv, ev);
        check("lb_0x23", rv, 32'hFFFFFF80);
        do_txn(0, 1'b0, 1'b1, 32'h21, 32'h0, 3'b100, rv, ev);
        check("lbu_0x21", rv, 32'h0000007F);
        do_txn(0, 1'b0, 1'b1, 32'h22, 32'h0, 3'b001, rv, ev);
        check("lh_0x22", rv, 32'hFFFF80FF);
        do_txn(0, 1'b0, 1'b1, 32'h20, 32'h0, 3'b101, rv, ev);
        check("lhu_0x20", rv, 32'h00007F01);

        // byte store merge; store with MemRead also set acts as a store
        do_txn(0, 1'b1, 1'b1, 32'h30, 32'h11223344, 3'b010, rv, ev);
        do_txn(0, 1'b1, 1'b0, 32'h31, 32'hFFFFFFAB, 3'b000, rv, ev);
        do_txn(0, 1'b0, 1'b1, 32'h30, 32'h0, 3'b010, rv, ev);
        check("sb_merge", rv, 32'h1122AB44);

        // reset while a store is waiting: abandoned, nothing written
        set_req(0, 1'b1, 1'b0, 32'h40, 32'h55, 3'b010);
        @(posedge clk);
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async_rdy", rdy0, 1'b0);
        check("rst_async_data", rdata0, 32'd0);
        repeat (2) begin
            @(negedge clk);
            check("rst_hold_rdy", rdy0, 1'b0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_rdy", rdy0, 1'b0);
        end
        $display("txn dut=0 RST during SW @40");
        do_txn(0, 1'b0, 1'b1, 32'h40, 32'h0, 3'b010, rv, ev);
        check("rst_no_commit", rv, 32'd0);

        // misaligned word store
        do_txn(0, 1'b1, 1'b0, 32'h42, 32'h1, 3'b010, rv, ev);
`ifdef DMEM_RESPONDER_ERR_EN
        check("sw_mis_err", ev, 1'b1);
`endif
        do_txn(0, 1'b0, 1'b1, 32'h40, 32'h0, 3'b010, rv, ev);
`ifdef DMEM_RESPONDER_ERR_EN
        check("sw_mis_suppressed", rv, 32'd0);
`else
        check("sw_mis_aligned", rv, 32'd1);
`endif

        // LATENCY=1: request held for 4 cycles completes twice
        pulses = 0;
        set_req(1, 1'b1, 1'b0, 32'h4, 32'h600DCAFE, 3'b010);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rdy1) pulses++;
            check("lat1_pattern", rdy1, (k % 2 == 0) ? 1'b1 : 1'b0);
        end
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        @(negedge clk);
        check("lat1_quiet", rdy1, 1'b0);
        check("lat1_pulses", pulses, 2);
        m_store(1, 32'h4, 32'h600DCAFE, 3'b010);
        $display("txn dut=1 ST held 4 cycles pulses=%0d", pulses);
        do_txn(1, 1'b0, 1'b1, 32'h4, 32'h0, 3'b010, rv, ev);
        check("lat1_lw", rv, 32'h600DCAFE);
        do_txn(1, 1'b1, 1'b0, 32'h6, 32'h0000BEEF, 3'b001, rv, ev);
        do_txn(1, 1'b0, 1'b1, 32'h6, 32'h0, 3'b001, rv, ev);
        check("lat1_lh", rv, 32'hFFFFBEEF);

        // randomized traffic against the model (addresses span twice the storage)
        for (int n = 0; n < 150; n++) begin
            ra = 32'($urandom_range(0, 2 * BYTES - 1));
            op = $urandom_range(0, 2);
            do_txn(0, op != 1, op != 0, ra, $urandom, 3'($urandom_range(0, 7)), rv, ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter XLEN, default 32: data and address width.
REQ-002 SHALL have parameter MEM_WORDS, default 1024: storage depth in XLEN-bit words, power of two.
REQ-003 SHALL have parameter LATENCY, default 2: cycles from request sample to o_DM_data_ready, legal range 1..15.
REQ-004 SHALL have port i_clk, input, 1: single clock; all logic on the rising edge.
REQ-005 SHALL have port i_rst, input, 1: one clock; reset asynchronous, active-low.
REQ-006 SHALL have port i_DM_Addr, input, XLEN: byte address from the hart.
REQ-007 SHALL have port i_DM_Wd, input, XLEN: store data, right-aligned.
REQ-008 SHALL have port i_DM_Wen, input, 1: store request.
REQ-009 SHALL have port i_DM_MemRead, input, 1: load request.
REQ-010 SHALL have port i_DM_f3, input, 3: RV32 funct3 size/sign code.
REQ-011 SHALL have port o_DM_data_ready, output, 1: one-cycle completion pulse.
REQ-012 SHALL have port o_DM_ReadData, output, XLEN: load result, extended per f3.

Function
REQ-013 SHALL implement FSM IDLE, WAIT, RESP; IDLE samples a request when i_DM_Wen or i_DM_MemRead is 1.
REQ-014 SHALL latch addr, wd, f3 and op into internal registers on sample; later input changes SHALL not affect the access.
REQ-015 SHALL treat i_DM_Wen=1 with i_DM_MemRead=1 as a store; load is ignored.
REQ-016 SHALL go IDLE->RESP when LATENCY=1; otherwise IDLE->WAIT, counter loaded with LATENCY-2, WAIT->RESP when counter is 0.
REQ-017 SHALL assert o_DM_data_ready exactly one cycle, in RESP, LATENCY cycles after the sample edge; RESP->IDLE unconditionally.
REQ-018 SHALL not sample a new request in RESP; a request held across RESP is sampled again in the following IDLE cycle.
REQ-019 SHALL commit stores in RESP with byte enables: f3=000 SB one byte, 001 SH two bytes, 010 SW four bytes; little-endian lane = addr[1:0].
REQ-020 SHALL return loads in RESP: 000 LB sign-extend, 001 LH sign-extend, 010 LW, 100 LBU zero-extend, 101 LHU zero-extend.
REQ-021 SHALL treat f3 011, 110, 111 as LW/SW.
REQ-022 SHALL drive o_DM_ReadData to 0 whenever o_DM_data_ready is 0 and for stores.
REQ-023 SHALL index storage by addr[log2(MEM_WORDS)+1:2]; upper bits ignored (wrap) when the configuration feature is off.
REQ-024 SHALL align down misaligned accesses when the feature is off: halfword ignores addr[0], word ignores addr[1:0].

Reset
REQ-025 SHALL on i_rst=0 immediately force state IDLE, counter 0, o_DM_data_ready 0, o_DM_ReadData 0, latched request cleared.
REQ-026 SHALL abandon any in-flight access on reset, with no store commit; storage contents are not cleared.
REQ-027 SHALL sample no request on the first edge where i_rst is 1 only when i_rst was deasserted asynchronously before that edge. If so, normal sampling applies.

Configuration
REQ-028 SHALL provide macro DMEM_RESPONDER_ERR_EN; when defined, add port o_DM_err, output, 1, reset 0.
REQ-029 SHALL with DMEM_RESPONDER_ERR_EN raise o_DM_err with o_DM_data_ready for misaligned access (half addr[0]=1, word addr[1:0]!=0) or addr >= 4*MEM_WORDS.
REQ-030 SHALL with DMEM_RESPONDER_ERR_EN, on error, suppress the store and force o_DM_ReadData to 0; timing is unchanged.
REQ-031 SHALL without DMEM_RESPONDER_ERR_EN have no o_DM_err port and follow REQ-023/REQ-024.

Verification
REQ-032 SHALL cover: LATENCY=2, SW 0xDEADBEEF @0x10, then LW @0x10 -> ready 2 cycles after each sample, read 0xDEADBEEF.
REQ-033 SHALL cover: word 0x80FF7F01 @0x20; LB @0x23 -> 0xFFFFFF80; LBU @0x21 -> 0x0000007F; LH @0x22 -> 0xFFFF80FF; LHU @0x20 -> 0x00007F01.
REQ-034 SHALL cover: SB 0xAB @0x31 over word 0x11223344 -> LW @0x30 returns 0x1122AB44.
REQ-035 SHALL cover: i_rst=0 during WAIT of SW 0x55 @0x40 (prior 0) -> ready never pulses; LW @0x40 after reset returns 0.
REQ-036 SHALL cover: LATENCY=1, request held high for 4 cycles -> ready pulses on alternate cycles (two completions).
REQ-037 SHALL cover, with DMEM_RESPONDER_ERR_EN: SW 0x1 @0x42 -> o_DM_err=1 with ready; LW @0x40 returns prior value; without macro same SW writes word @0x40.
